// File: rtl/core_if_pkg.sv
// Shared types for the instruction-fetch stage.
//   IF_regs_t     : fetch-to-decode pipeline register {fetch_pc, fetch_pc4}
//   fetch_state_t : fetch request FSM state
//   pc_plus4      : sequential PC step (wraps modulo 2^64)
package core_if_pkg;

  typedef struct packed {
    logic [63:0] fetch_pc;
    logic [63:0] fetch_pc4;
  } IF_regs_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 -- decode treats this as a bubble, so no valid bit is needed.
  localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;
  localparam logic [63:0] PC_STEP     = 64'd4;

  function automatic logic [63:0] pc_plus4(input logic [63:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/core_if_fetch_redirect_sel.sv
// Priority select of the fetch redirect target.
// Ports:
//   take_exception_i      : highest priority, target EXC_VECTOR
//   eret_i / epc_i        : return from exception, target epc_i
//   branch_taken_i / pc_branch_i : taken branch, target pc_branch_i
//   jump_i / jump_addr_i  : jump, target jump_addr_i (lowest priority)
//   redirect_o            : any redirect source active
//   target_o              : selected target (zero when no redirect)
module fetch_redirect_sel #(
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_8000_0180
) (
  input  logic        take_exception_i,
  input  logic        eret_i,
  input  logic [63:0] epc_i,
  input  logic        branch_taken_i,
  input  logic [63:0] pc_branch_i,
  input  logic        jump_i,
  input  logic [63:0] jump_addr_i,
  output logic        redirect_o,
  output logic [63:0] target_o
);

  always_comb begin
    redirect_o = 1'b1;
    target_o   = '0;
    if (take_exception_i) begin
      target_o = EXC_VECTOR;
    end else if (eret_i) begin
      target_o = epc_i;
    end else if (branch_taken_i) begin
      target_o = pc_branch_i;
    end else if (jump_i) begin
      target_o = jump_addr_i;
    end else begin
      redirect_o = 1'b0;
    end
  end

endmodule

// File: rtl/core_if.sv
// Instruction-fetch stage. Owns the 64-bit PC and runs a single-outstanding
// request/response handshake with instruction memory, applying redirects
// from exception, ERET, branch and jump.
// Ports:
//   clock, reset (async, active-low)
//   stall          : hold IF outputs and PC
//   flush          : squash next IF output to a bubble
//   take_exception, eret/epc, branch_taken/pc_branch, jump/jump_addr : redirects
//   imem_req/imem_addr : level request, address = req_pc
//   imem_ack/imem_rdata: response, at least one cycle after the request
//   IF_regs, inst  : {fetch_pc, fetch_pc4} and instruction to decode (0 = bubble)
//   fetch_busy     : request outstanding with no ack this cycle
module core_if
  import core_if_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_0040_0000,
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_8000_0180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        take_exception,
  input  logic        eret,
  input  logic [63:0] epc,
  input  logic        branch_taken,
  input  logic [63:0] pc_branch,
  input  logic        jump,
  input  logic [63:0] jump_addr,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output IF_regs_t    IF_regs,
  output logic [31:0] inst,
  output logic        fetch_busy
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;
  logic [63:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  IF_regs_t     if_regs_q, if_regs_d;
  logic [31:0]  inst_q, inst_d;

  logic         redirect;
  logic [63:0]  target;

  fetch_redirect_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_sel (
    .take_exception_i (take_exception),
    .eret_i           (eret),
    .epc_i            (epc),
    .branch_taken_i   (branch_taken),
    .pc_branch_i      (pc_branch),
    .jump_i           (jump),
    .jump_addr_i      (jump_addr),
    .redirect_o       (redirect),
    .target_o         (target)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    if_regs_d   = if_regs_q;
    inst_d      = inst_q;

    if (redirect) begin
      // A redirect overrides stall: the output always becomes a bubble.
      pc_d      = target;
      inst_d    = INST_BUBBLE;
      if_regs_d = '0;
      unique case (state_q)
        FS_IDLE: begin
          state_d  = FS_WAIT;
          req_pc_d = target;
        end
        FS_WAIT: begin
          if (imem_ack) begin
            // Response arriving now is for the old path: drop it and
            // reissue straight at the new target.
            req_pc_d = target;
            kill_d   = 1'b0;
          end else begin
            // Request still in flight; its response must be discarded.
            kill_d = 1'b1;
          end
        end
        FS_HOLD: begin
          state_d     = FS_IDLE;
          hold_pc_d   = '0;
          hold_inst_d = INST_BUBBLE;
        end
        default: state_d = FS_IDLE;
      endcase
    end else begin
      unique case (state_q)
        FS_IDLE: begin
          state_d  = FS_WAIT;
          req_pc_d = pc_q;
          if (!stall) begin
            inst_d    = INST_BUBBLE;
            if_regs_d = '0;
          end
        end
        FS_WAIT: begin
          if (!imem_ack) begin
            if (!stall) begin
              inst_d    = INST_BUBBLE;
              if_regs_d = '0;
            end
          end else if (kill_q) begin
            // Stale response from before a redirect: reissue at the new pc.
            kill_d    = 1'b0;
            req_pc_d  = pc_q;
            inst_d    = INST_BUBBLE;
            if_regs_d = '0;
          end else if (!stall) begin
            inst_d             = imem_rdata;
            if_regs_d.fetch_pc  = req_pc_q;
            if_regs_d.fetch_pc4 = pc_plus4(req_pc_q);
            pc_d               = pc_plus4(req_pc_q);
            req_pc_d           = pc_plus4(req_pc_q);
          end else begin
            // Decode cannot take it yet; park the instruction.
            hold_pc_d   = req_pc_q;
            hold_inst_d = imem_rdata;
            state_d     = FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (!stall) begin
            inst_d             = hold_inst_q;
            if_regs_d.fetch_pc  = hold_pc_q;
            if_regs_d.fetch_pc4 = pc_plus4(hold_pc_q);
            pc_d               = pc_plus4(hold_pc_q);
            req_pc_d           = pc_plus4(hold_pc_q);
            state_d            = FS_WAIT;
          end
        end
        default: state_d = FS_IDLE;
      endcase

      // Flush only squashes the visible output; PC and request proceed.
      if (flush) begin
        inst_d    = INST_BUBBLE;
        if_regs_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FS_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      kill_q      <= 1'b0;
      hold_pc_q   <= '0;
      hold_inst_q <= INST_BUBBLE;
      if_regs_q   <= '0;
      inst_q      <= INST_BUBBLE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      if_regs_q   <= if_regs_d;
      inst_q      <= inst_d;
    end
  end

  assign imem_req   = (state_q == FS_WAIT);
  assign imem_addr  = req_pc_q;
  assign fetch_busy = (state_q == FS_WAIT) && !imem_ack;
  assign IF_regs    = if_regs_q;
  assign inst       = inst_q;

endmodule
